// File: rtl/ext_pkg.sv
// Shared extension-mode encodings for the decode stage and the extender pipeline.
package ext_pkg;

    localparam int EOP_W = 3;

    localparam logic [EOP_W-1:0] EXT_SIGN  = 3'b000;
    localparam logic [EOP_W-1:0] EXT_ZERO  = 3'b001;
    localparam logic [EOP_W-1:0] EXT_UPPER = 3'b010;
    localparam logic [EOP_W-1:0] EXT_BR    = 3'b011;
    localparam logic [EOP_W-1:0] EXT_SB    = 3'b100;
    localparam logic [EOP_W-1:0] EXT_UB    = 3'b101;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: computes the OUT_W value for one eop mode
// and flags reserved modes.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic [IMM_W-1:0] imm,
    input  logic [EOP_W-1:0] eop,
    output logic [OUT_W-1:0] value,
    output logic             err
);

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;

    assign sign_ext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign zero_ext = {{(OUT_W-IMM_W){1'b0}}, imm};

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (eop)
            EXT_SIGN:  value = sign_ext;
            EXT_ZERO:  value = zero_ext;
            EXT_UPPER: value = {imm, {(OUT_W-IMM_W){1'b0}}};
            // Word offset: the two MSBs shifted out are simply dropped.
            EXT_BR:    value = {sign_ext[OUT_W-3:0], 2'b00};
            EXT_SB:    value = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            EXT_UB:    value = {{(OUT_W-8){1'b0}}, imm[7:0]};
            default: begin
                value = '0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined extender: extends {imm, eop} at push time and queues the result in a
// DEPTH-entry in-order buffer with valid/ready handshakes on both sides.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [EOP_W-1:0] eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
    output logic             out_err,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (IMM_W < 8 || IMM_W > OUT_W - 2) begin : g_bad_imm_w
        $error("ext_pipe: IMM_W must satisfy 8 <= IMM_W <= OUT_W-2");
    end
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ext_pipe: DEPTH must be a power of two");
    end
    if (CNT_W < $clog2(DEPTH+1)) begin : g_bad_cnt_w
        $error("ext_pipe: CNT_W too narrow for DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [OUT_W-1:0] mem_value [DEPTH];
    logic             mem_err   [DEPTH];
    logic [OUT_W-1:0] core_value;
    logic             core_err;
    logic             push;
    logic             pop;

    ext_core #(
        .IMM_W (IMM_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm   (imm),
        .eop   (eop),
        .value (core_value),
        .err   (core_err)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready looks only at occupancy, never at out_ready.
    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is not reset; entries are only observed while counted as valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && !flush && wr_ptr_reg == PTR_W'(gi)) begin
                mem_value[gi] <= core_value;
                mem_err[gi]   <= core_err;
            end
        end
    end

    assign ext     = out_valid ? mem_value[rd_ptr_reg] : '0;
    assign out_err = out_valid ? mem_err[rd_ptr_reg]   : 1'b0;
    assign count   = count_reg;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: default build (16->32, DEPTH 2) and a wide
// variant (26->32, DEPTH 4) driven in lockstep against a queue-based model.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [25:0] imm26 = '0;
    logic [2:0]  eop = '0;

    logic        in_ready0, out_valid0, out_err0;
    logic [31:0] ext0;
    logic [1:0]  count0;
    logic        in_ready1, out_valid1, out_err1;
    logic [31:0] ext1;
    logic [2:0]  count1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    ext_pipe dut0 (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready0),
        .imm (imm26[15:0]), .eop (eop),
        .out_valid (out_valid0), .out_ready (out_ready),
        .ext (ext0), .out_err (out_err0), .count (count0)
    );

    ext_pipe #(.IMM_W(26), .OUT_W(32), .DEPTH(4)) dut1 (
        .clk (clk), .reset (reset), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready1),
        .imm (imm26), .eop (eop),
        .out_valid (out_valid1), .out_ready (out_ready),
        .ext (ext1), .out_err (out_err1), .count (count1)
    );

    // Arithmetic model of the extension rules; returns {err, value}.
    function automatic logic [32:0] model_ext(input logic [25:0] im, input int imm_w,
                                              input logic [2:0] mode);
        longint u, s, ub, sb, r;
        logic [63:0] rr;
        logic e;
        u  = longint'(im) % (64'sd1 <<< imm_w);
        s  = (u >= (64'sd1 <<< (imm_w - 1))) ? u - (64'sd1 <<< imm_w) : u;
        ub = u % 256;
        sb = (ub >= 128) ? ub - 256 : ub;
        e  = 1'b0;
        case (mode)
            3'd0:    r = s;
            3'd1:    r = u;
            3'd2:    r = u * (64'sd1 <<< (32 - imm_w));
            3'd3:    r = s * 4;
            3'd4:    r = sb;
            3'd5:    r = ub;
            default: begin r = 0; e = 1'b1; end
        endcase
        rr = r;
        return {e, rr[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("d0_count", 64'(count0), 64'(q0.size()));
        chk("d0_valid", 64'(out_valid0), 64'(q0.size() != 0));
        chk("d0_ext",   64'(ext0), (q0.size() != 0) ? 64'(q0[0][31:0]) : 64'd0);
        chk("d0_err",   64'(out_err0), (q0.size() != 0) ? 64'(q0[0][32]) : 64'd0);
        chk("d0_ready", 64'(in_ready0), 64'(q0.size() < 2));
        chk("d1_count", 64'(count1), 64'(q1.size()));
        chk("d1_valid", 64'(out_valid1), 64'(q1.size() != 0));
        chk("d1_ext",   64'(ext1), (q1.size() != 0) ? 64'(q1[0][31:0]) : 64'd0);
        chk("d1_err",   64'(out_err1), (q1.size() != 0) ? 64'(q1[0][32]) : 64'd0);
        chk("d1_ready", 64'(in_ready1), 64'(q1.size() < 4));
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic cyc(input logic iv, input logic [25:0] im, input logic [2:0] op,
                       input logic ordy, input logic fl);
        logic p0, w0, p1, w1;
        in_valid  = iv;
        imm26     = im;
        eop       = op;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            q0.delete();
            q1.delete();
        end else begin
            p0 = ordy && (q0.size() > 0);
            w0 = iv && (q0.size() < 2);
            p1 = ordy && (q1.size() > 0);
            w1 = iv && (q1.size() < 4);
            if (p0) void'(q0.pop_front());
            if (w0) q0.push_back(model_ext(im, 16, op));
            if (p1) void'(q1.pop_front());
            if (w1) q1.push_back(model_ext(im, 26, op));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        compare_all();
    endtask

    typedef struct {
        logic [2:0]  eop;
        logic [15:0] imm;
        logic [31:0] ext;
        logic        err;
    } vec_t;

    vec_t vec [7];

    initial begin
        vec[0] = '{3'b000, 16'h8001, 32'hFFFF8001, 1'b0};
        vec[1] = '{3'b001, 16'h8001, 32'h00008001, 1'b0};
        vec[2] = '{3'b010, 16'h1234, 32'h12340000, 1'b0};
        vec[3] = '{3'b011, 16'hFFFF, 32'hFFFFFFFC, 1'b0};
        vec[4] = '{3'b100, 16'h0080, 32'hFFFFFF80, 1'b0};
        vec[5] = '{3'b101, 16'h12F0, 32'h000000F0, 1'b0};
        vec[6] = '{3'b110, 16'h5A5A, 32'h00000000, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid0), 64'd0);
        chk("rst_ext",   64'(ext0), 64'd0);
        chk("rst_count", 64'(count0), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready0), 64'd1);
        chk("rst_in_ready1", 64'(in_ready1), 64'd1);

        // Table: one push per mode, result one cycle later, then drained
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, {10'd0, vec[i].imm}, vec[i].eop, 1'b1, 1'b0);
            chk("tbl_valid", 64'(out_valid0), 64'd1);
            chk("tbl_ext",   64'(ext0), 64'(vec[i].ext));
            chk("tbl_err",   64'(out_err0), 64'(vec[i].err));
            $display("vec %0d: eop=%b imm=%h -> ext=%h err=%b", i, vec[i].eop, vec[i].imm,
                     ext0, out_err0);
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            chk("tbl_drain", 64'(out_valid0), 64'd0);
        end

        // Wide variant branch offset
        cyc(1'b1, 26'h2000000, 3'b011, 1'b1, 1'b0);
        chk("var_br", 64'(ext1), 64'hF8000000);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: A, B accepted, C refused; then drain in order
        cyc(1'b1, 26'h0000AAA, 3'b001, 1'b0, 1'b0);
        cyc(1'b1, 26'h0000BBB, 3'b001, 1'b0, 1'b0);
        chk("bp_count", 64'(count0), 64'd2);
        chk("bp_in_ready", 64'(in_ready0), 64'd0);
        cyc(1'b1, 26'h0000CCC, 3'b001, 1'b0, 1'b0);
        chk("bp_count_hold", 64'(count0), 64'd2);
        chk("bp_hold_a", 64'(ext0), 64'h00000AAA);
        cyc(1'b1, 26'h0000CCC, 3'b001, 1'b1, 1'b0);
        chk("bp_head_b", 64'(ext0), 64'h00000BBB);
        cyc(1'b1, 26'h0000CCC, 3'b001, 1'b1, 1'b0);
        chk("bp_head_c", 64'(ext0), 64'h00000CCC);
        repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_empty", 64'(count0), 64'd0);

        // Simultaneous push/pop at count 1
        cyc(1'b1, 26'($urandom), 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 26'($urandom), 3'($urandom_range(0, 5)), 1'b1, 1'b0);
            chk("pp_count", 64'(count0), 64'd1);
        end
        repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush at count 2 with a concurrent push
        cyc(1'b1, 26'h0001111, 3'b001, 1'b0, 1'b0);
        cyc(1'b1, 26'h0002222, 3'b001, 1'b0, 1'b0);
        cyc(1'b1, 26'h0003333, 3'b001, 1'b0, 1'b1);
        chk("fl_count", 64'(count0), 64'd0);
        chk("fl_valid", 64'(out_valid0), 64'd0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("fl_no_ghost", 64'(out_valid0), 64'd0);

        // Asynchronous reset mid-stream
        cyc(1'b1, 26'h0004444, 3'b001, 1'b0, 1'b0);
        cyc(1'b1, 26'h0005555, 3'b001, 1'b0, 1'b0);
        chk("ar_pre_valid", 64'(out_valid0), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid0), 64'd0);
        chk("ar_ext",   64'(ext0), 64'd0);
        chk("ar_count", 64'(count0), 64'd0);
        chk("ar_count1", 64'(count1), 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 26'h0008001, 3'b000, 1'b0, 1'b0);
        chk("ar_first_push", 64'(ext0), 64'hFFFF8001);
        repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Variant fill to DEPTH 4, then wrap-around traffic
        for (int i = 0; i < 4; i++) cyc(1'b1, 26'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        chk("v_full_count", 64'(count1), 64'd4);
        chk("v_full_ready", 64'(in_ready1), 64'd0);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 26'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 3) != 0), 26'($urandom), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
